mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port program/data memory between two bus masters: M0 is the CPU control/datapath, M1 is the program loader / debug port.
- Sits between both masters and the memory macro.
- Provides a req/ack transaction handshake, round-robin arbitration, an optional lock for back-to-back transfers, and a starvation cap on locking.

Parameters:
- DATA_W, 8, memory word width.
- ADDR_W, 8, memory address width.
- LOCK_MAX, 4, maximum consecutive locked transactions while the other master waits; range 1..15.

Ports:
- CLK  in  1  system clock. One clock domain; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- m0_req  in  1  M0 transaction request; held until m0_ack.
- m0_we  in  1  M0 write (1) or read (0); stable while m0_req is high.
- m0_lock  in  1  M0 asks to keep the grant for its next request.
- m0_addr  in  ADDR_W  M0 address.
- m0_wdata  in  DATA_W  M0 write data.
- m0_ack  out  1  one-cycle completion pulse for M0.
- m0_rdata  out  DATA_W  M0 read data; valid while m0_ack is high, held afterwards.
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_ack, m1_rdata: same as M0, for M1.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data; synchronous read, valid one cycle after the address.
- grant  out  2  one-hot current owner, for debug; 00 when idle.

Behaviour:
- Reset (synchronous, RST=1 at a rising edge):
  - state=IDLE, grant=00, both acks=0, both rdata=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - last_served=M1, so M0 wins the first tie.
  - lock_owner=none, lock_cnt=0.
  - A transaction in flight is abandoned: no ack, no further write.
- State machine:
  - IDLE:
    - Arbitrate among asserted reqs.
    - If lock_owner is set and its req is high, it wins, unless the other req is high and lock_cnt==LOCK_MAX; then the other master wins.
    - Otherwise, with a single req, that master wins; with both, the master that is not last_served wins.
    - The winner is registered into grant and the state goes to ACCESS. With no req, stay in IDLE.
  - ACCESS (1 cycle):
    - mem_addr/mem_wdata come from the granted master's inputs.
    - mem_we = granted master's we.
    - Next state is RESP.
  - RESP (1 cycle):
    - mem_we=0.
    - Register mem_rdata into the granted master's rdata, and pulse its ack in this cycle (ack registered on the ACCESS->RESP edge; rdata bypassed from mem_rdata in RESP and captured for hold).
    - last_served = granted master.
    - If the granted master's lock is high: lock_owner = that master, and lock_cnt increments (saturating at LOCK_MAX) when the other req is high.
    - Otherwise: lock_owner=none, lock_cnt=0.
    - Next state is IDLE and grant goes to 00.
  - A lock that loses arbitration due to the cap is cleared (lock_owner=none, lock_cnt=0).
- Latency, uncontended: req first high in IDLE cycle N -> ack in cycle N+2. Throughput is one transaction per 3 cycles.
- The master must deassert req in the cycle after ack. A req still high in the cycle after ack is treated as a new request.
- mem_addr/mem_wdata drive 0 outside ACCESS; mem_we is 1 only in ACCESS with a write.
- A req dropping mid-transaction (protocol violation): the transaction still completes and is acked.
- Both reqs arriving in the same cycle: round-robin resolves; there are no simultaneous acks, ever.
- A write returns mem_rdata in rdata (don't-care for the master); ack is still pulsed.

Decomposition:
- Shared package mem_bus_pkg:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - master index constants (M_CPU=0, M_LDR=1);
  - default DATA_W/ADDR_W.
- One sub-module, rr_pick2: combinational 2-way picker (req[1:0], last, lock_owner, cap_hit -> winner, valid), shared with future IO arbiters.

Test Plan:
- Reset then M0 read addr 8'h10, memory holds 8'hA5 -> mem_addr=8'h10 in cycle 1, m0_ack and m0_rdata=8'hA5 in cycle 2, m1_ack stays 0.
- M1 write addr 8'h20 data 8'h3C -> mem_we=1 for exactly one cycle with mem_addr=8'h20, mem_wdata=8'h3C; a later M0 read of 8'h20 returns 8'h3C.
- Both reqs in the same cycle after reset, then both held -> grants alternate M0, M1, M0, M1; each ack 3 cycles apart.
- M1 holds lock with M0 requesting, LOCK_MAX=4 -> 4 consecutive M1 transactions, then M0 granted; after that M1 is granted again.
- RST asserted during ACCESS of an M0 write -> no m0_ack, mem_we=0 the next cycle, grant=00; an M0 request after reset is served normally.
- No requests for 10 cycles -> grant=00, mem_we=0, mem_addr=0 throughout.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for memory-bus arbiters: FSM encoding, master indices
// and default bus widths.
package mem_bus_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   localparam int M_CPU = 0;
   localparam int M_LDR = 1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker with a lock holder that keeps priority until the
// starvation cap hands the next slot to the waiting master.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic [1:0] lock_owner,
   input  logic       cap_hit,
   output logic       winner,
   output logic       valid
);

   always_comb begin
      valid  = |req;
      winner = 1'b0;
      if (lock_owner[0] && req[0]) begin
         winner = req[1] && cap_hit;
      end else if (lock_owner[1] && req[1]) begin
         winner = !(req[0] && cap_hit);
      end else if (req == 2'b10) begin
         winner = 1'b1;
      end else if (req == 2'b11) begin
         winner = ~last;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous-read memory between the CPU (M0) and the
// loader/debug port (M1): IDLE -> ACCESS -> RESP per transaction.
module mem_arbiter
   import mem_bus_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int LOCK_MAX = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        grant
);

   localparam logic [3:0] CAP = 4'(LOCK_MAX);

   logic [1:0]        state;
   logic [1:0]        grant_q;
   logic              last_served;
   logic [1:0]        lock_owner;
   logic [3:0]        lock_cnt;
   logic              m0_ack_q, m1_ack_q;
   logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
   logic              sel, win, pick_valid, cap_hit, lock_lost;
   logic              own_lock, other_req, in_access, in_resp;

   assign sel       = grant_q[M_LDR];
   assign in_access = (state == ST_ACCESS);
   assign in_resp   = (state == ST_RESP);
   assign cap_hit   = (lock_cnt == CAP);
   assign own_lock  = sel ? m1_lock : m0_lock;
   assign other_req = sel ? m0_req : m1_req;

   rr_pick2 u_pick (
      .req        ({m1_req, m0_req}),
      .last       (last_served),
      .lock_owner (lock_owner),
      .cap_hit    (cap_hit),
      .winner     (win),
      .valid      (pick_valid)
   );

   // The lock holder still wants the bus but the cap handed the slot away.
   assign lock_lost = |(lock_owner & {m1_req, m0_req}) && !lock_owner[win];

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (in_access) begin
         mem_addr  = sel ? m1_addr : m0_addr;
         mem_wdata = sel ? m1_wdata : m0_wdata;
         mem_we    = sel ? m1_we : m0_we;
      end
   end

   // Read data is bypassed during RESP and held from the capture register after.
   assign m0_rdata = (in_resp && grant_q[M_CPU]) ? mem_rdata : m0_rdata_q;
   assign m1_rdata = (in_resp && grant_q[M_LDR]) ? mem_rdata : m1_rdata_q;
   assign m0_ack   = m0_ack_q;
   assign m1_ack   = m1_ack_q;
   assign grant    = grant_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= ST_IDLE;
         grant_q     <= 2'b00;
         last_served <= 1'b1;
         lock_owner  <= 2'b00;
         lock_cnt    <= 4'd0;
         m0_ack_q    <= 1'b0;
         m1_ack_q    <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         m0_ack_q <= 1'b0;
         m1_ack_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  grant_q <= win ? 2'b10 : 2'b01;
                  state   <= ST_ACCESS;
                  if (lock_lost) begin
                     lock_owner <= 2'b00;
                     lock_cnt   <= 4'd0;
                  end
               end
            end
            ST_ACCESS: begin
               m0_ack_q <= grant_q[M_CPU];
               m1_ack_q <= grant_q[M_LDR];
               state    <= ST_RESP;
            end
            ST_RESP: begin
               if (grant_q[M_CPU]) m0_rdata_q <= mem_rdata;
               if (grant_q[M_LDR]) m1_rdata_q <= mem_rdata;
               last_served <= sel;
               if (own_lock) begin
                  lock_owner <= grant_q;
                  // A new lock holder starts counting from scratch.
                  if (lock_owner != grant_q) begin
                     lock_cnt <= other_req ? 4'd1 : 4'd0;
                  end else if (other_req && !cap_hit) begin
                     lock_cnt <= lock_cnt + 4'd1;
                  end
               end else begin
                  lock_owner <= 2'b00;
                  lock_cnt   <= 4'd0;
               end
               grant_q <= 2'b00;
               state   <= ST_IDLE;
            end
            default: begin
               grant_q <= 2'b00;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous-read memory model.
module tb_mem_arbiter;

   logic       CLK, RST;
   logic       m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic       m0_ack, m1_ack, mem_we;
   logic [7:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0] grant;

   logic [7:0] mem_arr [256];
   logic [7:0] rd;
   int         lat;
   int         checks   = 0;
   int         failures = 0;
   logic [1:0] exp_g3 [12];
   logic [1:0] exp_g4 [21];

   mem_arbiter #(.DATA_W(8), .ADDR_W(8), .LOCK_MAX(4)) dut (
      .CLK(CLK), .RST(RST),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .grant(grant)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Memory model: synchronous read, write on strobe, fixed contents on reset.
   always @(posedge CLK) begin
      mem_rdata <= mem_arr[mem_addr];
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      if (RST) begin
         mem_arr[8'h10] <= 8'hA5;
         mem_arr[8'h44] <= 8'hC3;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic xact(input logic m, input logic we, input logic [7:0] addr,
                       input logic [7:0] wd, output logic [7:0] rdo, output int lato);
      if (!m) begin
         m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
      end else begin
         m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd;
      end
      lato = -1;
      rdo  = 8'h00;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (m ? m1_ack : m0_ack) begin
            lato = i;
            rdo  = m ? m1_rdata : m0_rdata;
            break;
         end
         step();
      end
      step();
      if (!m) begin m0_req = 1'b0; m0_we = 1'b0; end
      else begin m1_req = 1'b0; m1_we = 1'b0; end
   endtask

   initial begin
      RST = 1'b1;
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
      exp_g3 = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
      exp_g4 = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00,
                 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10,
                 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};

      // Reset values
      step(); step();
      RST = 1'b0;
      @(negedge CLK);
      check("rst_grant", grant, 2'b00);
      check("rst_m0_ack", m0_ack, 0);
      check("rst_m1_ack", m1_ack, 0);
      check("rst_m0_rdata", m0_rdata, 0);
      check("rst_m1_rdata", m1_rdata, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);

      // M0 read of 0x10, cycle by cycle
      step();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10;
      @(negedge CLK);
      check("rd_c0_grant", grant, 2'b00);
      check("rd_c0_addr", mem_addr, 0);
      step();
      @(negedge CLK);
      check("rd_c1_grant", grant, 2'b01);
      check("rd_c1_addr", mem_addr, 8'h10);
      check("rd_c1_we", mem_we, 0);
      check("rd_c1_ack", m0_ack, 0);
      step();
      @(negedge CLK);
      check("rd_c2_ack", m0_ack, 1);
      check("rd_c2_rdata", m0_rdata, 8'hA5);
      check("rd_c2_m1_ack", m1_ack, 0);
      step();
      m0_req = 1'b0;
      @(negedge CLK);
      check("rd_c3_ack", m0_ack, 0);
      check("rd_c3_hold", m0_rdata, 8'hA5);
      check("rd_c3_grant", grant, 2'b00);

      // M1 write 0x3C to 0x20, then M0 reads it back
      step();
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h20; m1_wdata = 8'h3C;
      @(negedge CLK);
      check("wr_c0_we", mem_we, 0);
      step();
      @(negedge CLK);
      check("wr_c1_we", mem_we, 1);
      check("wr_c1_addr", mem_addr, 8'h20);
      check("wr_c1_wdata", mem_wdata, 8'h3C);
      check("wr_c1_grant", grant, 2'b10);
      step();
      @(negedge CLK);
      check("wr_c2_we", mem_we, 0);
      check("wr_c2_ack", m1_ack, 1);
      step();
      m1_req = 1'b0; m1_we = 1'b0;
      @(negedge CLK);
      check("wr_c3_we", mem_we, 0);
      step();
      xact(1'b0, 1'b0, 8'h20, 8'h00, rd, lat);
      check("rb_lat", lat, 2);
      check("rb_data", rd, 8'h3C);

      // Simultaneous requests after reset, both held: strict alternation
      RST = 1'b1;
      step(); step();
      RST = 1'b0;
      m0_req = 1'b1; m0_addr = 8'h10;
      m1_req = 1'b1; m1_addr = 8'h44;
      for (int c = 0; c < 12; c++) begin
         @(negedge CLK);
         check($sformatf("rr_grant_%0d", c), grant, exp_g3[c]);
         check($sformatf("rr_m0_ack_%0d", c), m0_ack, (c == 2 || c == 8));
         check($sformatf("rr_m1_ack_%0d", c), m1_ack, (c == 5 || c == 11));
         if (c == 5) check("rr_m1_rdata", m1_rdata, 8'hC3);
         step();
      end
      m0_req = 1'b0; m1_req = 1'b0;
      step(); step();

      // M1 lock with M0 waiting: four locked M1 slots, then M0, then M1 again
      m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 8'h44;
      for (int c = 0; c < 21; c++) begin
         if (c == 3) begin m0_req = 1'b1; m0_addr = 8'h10; end
         if (c == 18) m0_req = 1'b0;
         @(negedge CLK);
         check($sformatf("lk_grant_%0d", c), grant, exp_g4[c]);
         check($sformatf("lk_m1_ack_%0d", c), m1_ack, (c % 3 == 2) && (c != 17));
         check($sformatf("lk_m0_ack_%0d", c), m0_ack, (c == 17));
         step();
      end
      m1_req = 1'b0; m1_lock = 1'b0;
      step(); step();

      // Reset during ACCESS of an M0 write abandons the transaction
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h30; m0_wdata = 8'h77;
      @(negedge CLK);
      check("ra_c0_grant", grant, 2'b00);
      step();
      RST = 1'b1;
      @(negedge CLK);
      check("ra_c1_we", mem_we, 1);
      check("ra_c1_grant", grant, 2'b01);
      step();
      RST = 1'b0; m0_req = 1'b0; m0_we = 1'b0;
      @(negedge CLK);
      check("ra_c2_ack", m0_ack, 0);
      check("ra_c2_we", mem_we, 0);
      check("ra_c2_grant", grant, 2'b00);
      check("ra_c2_rdata", m0_rdata, 0);
      check("ra_c2_addr", mem_addr, 0);
      step();
      @(negedge CLK);
      check("ra_c3_ack", m0_ack, 0);
      step();
      xact(1'b0, 1'b0, 8'h10, 8'h00, rd, lat);
      check("ra_post_lat", lat, 2);
      check("ra_post_data", rd, 8'hA5);

      // Ten idle cycles
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         check($sformatf("idle_grant_%0d", c), grant, 2'b00);
         check($sformatf("idle_we_%0d", c), mem_we, 0);
         check($sformatf("idle_addr_%0d", c), mem_addr, 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
